axis_pkt_gen: RTL and testbench

AXI4-Stream master-side traffic source. It produces packets of incrementing data on an AXIS master port and is the transmitting end that feeds the slave side of the stream FIFO. Software or the test harness programs length, count, gap and seed, then pulses start. The block is single-clock, and it is the bring-up and throughput-test source for the stream datapath.

---
 rtl/axis_pkg.sv | 16 +
 rtl/axis_if.sv | 16 +
 rtl/axis_pkt_gen.sv | 126 ++++++++++++
 tb/tb_axis_pkt_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types for the AXI4-Stream traffic generator: FSM state encoding
// and helpers used by the generator and its bench.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } axis_gen_state_e;

  // Index of the final beat for a programmed length; a length of 0 behaves as 1.
  function automatic logic [7:0] last_beat_idx8(input logic [7:0] len);
    return (len == 8'd0) ? 8'd0 : len - 8'd1;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream bundle (tvalid/tready/tdata/tlast) with master and slave views.
interface axis_if #(
  parameter int DATA_WIDTH = 8
) ();

  // Handshake: a beat transfers on any rising edge where tvalid && tready.
  // Once tvalid is high, tdata/tlast hold and tvalid stays high until that transfer.
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet source: programmable length/count/gap, incrementing data
// starting at a seed, stop at packet boundary, all outputs driven from flops.
module axis_pkt_gen
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  m_axis_clk,
  input  logic                  m_axis_rst,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [CNT_WIDTH-1:0]  cfg_pkt_cnt,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkts_sent,
  output axis_gen_state_e       state,
  axis_if.master                m_axis
);

  // The beat struct lives here because a package typedef cannot take DATA_WIDTH.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
  } axis_beat_t;

  axis_gen_state_e       state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, beat_q, last_idx;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkts_q, pkts_inc;
  logic [GAP_WIDTH-1:0]  gap_q, gap_cnt_q, gap_last;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  stop_q, done_q;
  logic                  fire, is_last, eop, stop_seen, run_done;
  axis_beat_t            beat;

  assign last_idx  = (len_q == '0) ? '0 : len_q - 1'b1;
  assign gap_last  = gap_q - 1'b1;
  assign pkts_inc  = pkts_q + 1'b1;
  assign is_last   = (beat_q == last_idx);
  assign fire      = (state_q == SEND) && m_axis.tready;
  assign eop       = fire && is_last;
  assign stop_seen = stop_q || cfg_stop;
  assign run_done  = ((pkt_cnt_q != '0) && (pkts_inc == pkt_cnt_q)) || stop_seen;

  // State register
  always_ff @(posedge m_axis_clk) begin
    if (m_axis_rst) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cfg_start) state_d = SEND;
      SEND: begin
        if (eop) begin
          if (run_done)         state_d = IDLE;
          else if (gap_q != '0) state_d = GAP;
          else                  state_d = SEND;
        end
      end
      GAP: begin
        if (stop_seen)                state_d = IDLE;
        else if (gap_cnt_q == gap_last) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only flops, so tready never reaches an output combinationally.
  always_comb begin
    beat.tdata    = data_q;
    beat.tlast    = (state_q == SEND) && is_last;
    m_axis.tvalid = (state_q == SEND);
    m_axis.tdata  = beat.tdata;
    m_axis.tlast  = beat.tlast;
    busy          = (state_q != IDLE);
    done          = done_q;
    pkts_sent     = pkts_q;
    state         = state_q;
  end

  // Configuration capture, beat/data/packet/gap counters
  always_ff @(posedge m_axis_clk) begin
    if (m_axis_rst) begin
      len_q     <= '0;
      pkt_cnt_q <= '0;
      gap_q     <= '0;
      beat_q    <= '0;
      data_q    <= '0;
      pkts_q    <= '0;
      gap_cnt_q <= '0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q != IDLE) && (state_d == IDLE);
      if (state_q == IDLE) begin
        stop_q    <= 1'b0;
        gap_cnt_q <= '0;
        if (cfg_start) begin
          len_q     <= cfg_len;
          pkt_cnt_q <= cfg_pkt_cnt;
          gap_q     <= cfg_gap;
          data_q    <= cfg_seed;
          beat_q    <= '0;
          pkts_q    <= '0;
        end
      end else begin
        if (cfg_stop) stop_q <= 1'b1;
        if (fire) begin
          data_q <= data_q + 1'b1;
          beat_q <= is_last ? '0 : beat_q + 1'b1;
          if (is_last) pkts_q <= pkts_inc;
        end
        gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + 1'b1 : '0;
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: scoreboard of expected beats, handshake
// monitor with stall/done checks, immediate assertions at every comparison.
module tb_axis_pkt_gen;
  import axis_pkg::*;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int CW = 8;
  localparam int GW = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  logic          cfg_start = 1'b0;
  logic          cfg_stop  = 1'b0;
  logic [LW-1:0] cfg_len   = '0;
  logic [CW-1:0] cfg_pkt_cnt = '0;
  logic [GW-1:0] cfg_gap   = '0;
  logic [DW-1:0] cfg_seed  = '0;
  logic          busy, done;
  logic [CW-1:0] pkts_sent;
  axis_gen_state_e state;

  axis_if #(.DATA_WIDTH(DW)) axis ();

  axis_pkt_gen #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW), .GAP_WIDTH(GW)
  ) dut (
    .m_axis_clk  (clk),
    .m_axis_rst  (rst),
    .cfg_start   (cfg_start),
    .cfg_stop    (cfg_stop),
    .cfg_len     (cfg_len),
    .cfg_pkt_cnt (cfg_pkt_cnt),
    .cfg_gap     (cfg_gap),
    .cfg_seed    (cfg_seed),
    .busy        (busy),
    .done        (done),
    .pkts_sent   (pkts_sent),
    .state       (state),
    .m_axis      (axis)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and monitor state
  logic [DW:0] exp_q[$];
  int hs_cyc[$];
  int cyc = 0;
  int ndone = 0;
  int last_tlast_cyc = -10;
  int start_cyc = 0;
  logic stall_prev = 1'b0;
  logic done_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_tvalid", 32'(axis.tvalid), 1);
        chk("stall_beat", 32'({axis.tlast, axis.tdata}), 32'({prev_last, prev_data}));
      end
      if (done_prev) chk("done_pulse", 32'(done), 0);
      if (axis.tvalid && axis.tready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", exp_q.size(), 1);
        else chk("beat", 32'({axis.tlast, axis.tdata}), 32'(exp_q.pop_front()));
        hs_cyc.push_back(cyc);
        if (axis.tlast) last_tlast_cyc = cyc;
      end
      if (done) begin
        ndone++;
        chk("done_busy", 32'(busy), 0);
        chk("done_tvalid", 32'(axis.tvalid), 0);
        chk("done_latency", cyc, last_tlast_cyc + 1);
      end
      stall_prev = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
      done_prev  = done;
    end
    cyc++;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int hs_at(input int i);
    return (i < hs_cyc.size()) ? hs_cyc[i] : -1;
  endfunction

  task automatic start_run(input int len, input int cnt, input int gap,
                           input logic [DW-1:0] seed, input int npush);
    int eff;
    logic [DW-1:0] d;
    eff = (len == 0) ? 1 : len;
    d = seed;
    cfg_len     = LW'(len);
    cfg_pkt_cnt = CW'(cnt);
    cfg_gap     = GW'(gap);
    cfg_seed    = seed;
    cfg_start   = 1'b1;
    start_cyc   = cyc;
    for (int p = 0; p < npush; p++)
      for (int b = 0; b < eff; b++) begin
        exp_q.push_back({b == eff - 1, d});
        d++;
      end
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n0;
    int i;
    n0 = ndone;
    i = 0;
    while (ndone == n0 && i < budget) begin
      tick();
      if (rnd) axis.tready = 1'($urandom_range(0, 1));
      i++;
    end
    chk("done_seen", ndone - n0, 1);
    axis.tready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    axis.tready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_tvalid", 32'(axis.tvalid), 0);
    chk("rst_tlast", 32'(axis.tlast), 0);
    chk("rst_tdata", 32'(axis.tdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pkts", 32'(pkts_sent), 0);
    chk("rst_state", 32'(state), 32'(IDLE));

    // Basic back-to-back run
    hs_cyc.delete();
    start_run(4, 2, 0, 8'h10, 2);
    s = start_cyc;
    chk("basic_busy", 32'(busy), 1);
    wait_done(40, 1'b0);
    chk("basic_first", hs_at(0), s + 1);
    chk("basic_span", hs_at(7) - hs_at(0), 7);
    chk("basic_pkts", 32'(pkts_sent), 2);
    chk("basic_drain", exp_q.size(), 0);

    // Inter-packet gap with data wrap
    hs_cyc.delete();
    start_run(3, 2, 2, 8'hFE, 2);
    s = start_cyc;
    wait_done(40, 1'b0);
    chk("gap_first", hs_at(0), s + 1);
    chk("gap_spacing", hs_at(3) - hs_at(2), 3);
    chk("gap_span", hs_at(5) - hs_at(0), 7);
    chk("gap_pkts", 32'(pkts_sent), 2);
    chk("gap_drain", exp_q.size(), 0);

    // Random backpressure
    start_run(4, 1, 0, 8'hA0, 1);
    wait_done(200, 1'b1);
    chk("bp_pkts", 32'(pkts_sent), 1);
    chk("bp_drain", exp_q.size(), 0);

    // Continuous run, stop on 2nd beat of packet 3
    start_run(5, 0, 0, 8'h40, 3);
    repeat (11) tick();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    wait_done(60, 1'b0);
    chk("stop_pkts", 32'(pkts_sent), 3);
    chk("stop_drain", exp_q.size(), 0);

    // Zero length means single-beat packets
    start_run(0, 3, 0, 8'h80, 3);
    wait_done(30, 1'b0);
    chk("len0_pkts", 32'(pkts_sent), 3);
    chk("len0_drain", exp_q.size(), 0);

    // Start while busy is ignored
    start_run(4, 1, 0, 8'h20, 1);
    tick();
    cfg_seed = 8'h99;
    cfg_len = 8'd2;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_done(30, 1'b0);
    repeat (3) tick();
    chk("busy_start_pkts", 32'(pkts_sent), 1);
    chk("busy_start_idle", 32'(state), 32'(IDLE));
    chk("busy_start_drain", exp_q.size(), 0);

    // New start in the done cycle
    start_run(2, 1, 0, 8'h30, 1);
    tick();
    tick();
    chk("done_cycle", 32'(done), 1);
    hs_cyc.delete();
    start_run(1, 1, 0, 8'h50, 1);
    s = start_cyc;
    wait_done(20, 1'b0);
    chk("restart_first", hs_at(0), s + 1);
    chk("restart_drain", exp_q.size(), 0);

    // Reset mid-packet while stalled
    axis.tready = 1'b0;
    start_run(6, 1, 0, 8'h60, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_tvalid", 32'(axis.tvalid), 0);
    chk("mid_rst_tlast", 32'(axis.tlast), 0);
    chk("mid_rst_tdata", 32'(axis.tdata), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_pkts", 32'(pkts_sent), 0);
    chk("mid_rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    axis.tready = 1'b1;
    start_run(6, 1, 0, 8'h60, 1);
    wait_done(30, 1'b0);
    chk("post_rst_pkts", 32'(pkts_sent), 1);

    tick();
    chk("final_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
